// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types and helpers for the data-memory responder
package dmem_responder_pkg;

    // Access size encoding; 2'b11 is reserved and always raises an error
    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10,
        MEM_RSVD = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } dmem_state_t;

    // Address is held at the widest supported width and truncated by the user
    localparam int MAX_ADDR_W = 32;

    typedef struct packed {
        logic [MAX_ADDR_W-1:0] addr;
        logic                  write;
        logic [31:0]           wdata;
        mem_size_t             size;
        logic                  sign;
    } dmem_req_t;

    // Misaligned half/word or reserved size
    function automatic logic access_error(input mem_size_t size, input logic [1:0] offset);
        logic err;
        case (size)
            MEM_BYTE: err = 1'b0;
            MEM_HALF: err = offset[0];
            MEM_WORD: err = (offset != 2'b00);
            default:  err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/dmem_responder_storage.sv
// rtl/dmem_responder_storage.sv - four byte-lane storage arrays, sync write, comb read
module dmem_storage #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [3:0]        lane_we,
    input  logic [ADDR_W-3:0] index,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] mem [0:DEPTH-1];

        // Each lane writes only its own byte when enabled
        always_ff @(posedge clk) begin
            if (lane_we[g]) begin
                mem[index] <= wdata[8*g +: 8];
            end
        end

        assign rdata[8*g +: 8] = mem[index];
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - memory-side responder with wait states, byte/half/word access
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    dmem_state_t       state;
    logic [3:0]        wait_cnt;
    dmem_req_t         req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        offset;
    logic              err;
    logic [3:0]        lane_en;
    logic [31:0]       lane_wdata;
    logic [3:0]        lane_we;
    logic [31:0]       rd_word;
    logic [31:0]       shifted;
    logic [31:0]       load_data;

    assign addr_q    = req_q.addr[ADDR_W-1:0];
    assign offset    = addr_q[1:0];
    assign err       = access_error(req_q.size, offset);
    assign req_ready = (state == IDLE) && !reset;

    // Lane enables and lane-replicated store data for the captured request
    always_comb begin
        lane_en    = 4'b0000;
        lane_wdata = req_q.wdata;
        case (req_q.size)
            MEM_BYTE: begin
                lane_en    = 4'b0001 << offset;
                lane_wdata = {4{req_q.wdata[7:0]}};
            end
            MEM_HALF: begin
                lane_en    = 4'b0011 << offset;
                lane_wdata = {2{req_q.wdata[15:0]}};
            end
            MEM_WORD: lane_en = 4'b1111;
            default:  lane_en = 4'b0000;
        endcase
    end

    // Stores commit only in an error-free ACCESS cycle that is not being reset
    assign lane_we = (state == ACCESS && !reset && !err && req_q.write) ? lane_en : 4'b0000;

    dmem_storage #(.ADDR_W(ADDR_W)) u_storage (
        .clk     (clk),
        .lane_we (lane_we),
        .index   (addr_q[ADDR_W-1:2]),
        .wdata   (lane_wdata),
        .rdata   (rd_word)
    );

    assign shifted = rd_word >> {offset, 3'b000};

    // Align the addressed bytes to bit 0 and extend
    always_comb begin
        load_data = shifted;
        case (req_q.size)
            MEM_BYTE: load_data = {{24{req_q.sign & shifted[7]}}, shifted[7:0]};
            MEM_HALF: load_data = {{16{req_q.sign & shifted[15]}}, shifted[15:0]};
            default:  load_data = shifted;
        endcase
    end

    // Request/response sequencing with registered response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_q.addr  <= MAX_ADDR_W'(req_addr);
                        req_q.write <= req_write;
                        req_q.wdata <= req_wdata;
                        req_q.size  <= mem_size_t'(req_size);
                        req_q.sign  <= req_sign;
                        if (WAIT_STATES == 0) begin
                            state <= ACCESS;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ACCESS: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= err;
                    rsp_rdata <= (err || req_q.write) ? 32'd0 : load_data;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;

    localparam int ADDR_W = 10;
    localparam int WS     = 2;

    logic              clk       = 1'b0;
    logic              reset     = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr  = '0;
    logic              req_write = 1'b0;
    logic [31:0]       req_wdata = 32'd0;
    logic [1:0]        req_size  = 2'd0;
    logic              req_sign  = 1'b0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ref_mem [0:(2**ADDR_W)-1];

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_STATES(WS)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .req_size  (req_size),
        .req_sign  (req_sign),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: byte-addressed little-endian memory with alignment rules
    function automatic void ref_op(input logic [ADDR_W-1:0] a, input logic w, input logic [31:0] wd,
                                   input logic [1:0] sz, input logic sg,
                                   output logic [31:0] rd, output logic e);
        int nbytes;
        logic [31:0] v;
        e  = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
        rd = 32'd0;
        if (e) return;
        nbytes = 1 << sz;
        if (w) begin
            for (int i = 0; i < nbytes; i++) ref_mem[a + i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < nbytes; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
            if (sg && nbytes < 4 && v[8*nbytes-1]) v = v | ~((32'd1 << (8 * nbytes)) - 32'd1);
            rd = v;
        end
    endfunction

    task automatic accept_req(input logic [ADDR_W-1:0] a, input logic w, input logic [31:0] wd,
                              input logic [1:0] sz, input logic sg, output bit ok);
        int t;
        ok = 1'b0;
        t  = 0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = wd; req_size = sz; req_sign = sg;
        while (t < 50) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            t++;
        end
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = ADDR_W'($urandom);
        req_wdata = $urandom;
        req_size  = 2'($urandom);
        req_write = 1'($urandom);
        req_sign  = 1'($urandom);
    endtask

    // Counts edges with the accept edge as edge 1
    task automatic wait_rsp(output int lat, output bit ok);
        lat = 1;
        ok  = 1'b0;
        while (lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic transact(input logic [ADDR_W-1:0] a, input logic w, input logic [31:0] wd,
                            input logic [1:0] sz, input logic sg, input int stall);
        logic [31:0] exp_rd;
        logic        exp_err;
        bit          ok;
        int          lat;
        ref_op(a, w, wd, sz, sg, exp_rd, exp_err);
        rsp_ready = (stall == 0);
        accept_req(a, w, wd, sz, sg, ok);
        if (!ok) return;
        wait_rsp(lat, ok);
        if (!ok) return;
        check("latency", 32'(lat), 32'(WS + 2));
        check("rdata", rsp_rdata, exp_rd);
        check("err", 32'(rsp_err), 32'(exp_err));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_rdata", rsp_rdata, exp_rd);
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        check("hs_req_ready_low", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("clear_valid", 32'(rsp_valid), 32'd0);
        check("clear_rdata", rsp_rdata, 32'd0);
        check("clear_err", 32'(rsp_err), 32'd0);
        check("ready_after_hs", 32'(req_ready), 32'd1);
    endtask

    initial begin
        bit ok;
        // Reset state
        repeat (2) begin
            @(posedge clk);
            #1;
            check("ready_in_reset", 32'(req_ready), 32'd0);
        end
        reset = 1'b0;
        #1;
        check("idle_ready", 32'(req_ready), 32'd1);
        check("idle_valid", 32'(rsp_valid), 32'd0);
        check("idle_rdata", rsp_rdata, 32'd0);
        check("idle_err", 32'(rsp_err), 32'd0);

        // Known contents for the region exercised below
        for (int i = 0; i < 16; i++) transact(ADDR_W'(i * 4), 1'b1, $urandom, 2'd2, 1'b0, 0);

        // Round trip and sub-word extension
        transact(10'h010, 1'b1, 32'hDEADBEEF, 2'd2, 1'b0, 0);
        transact(10'h010, 1'b0, 32'd0, 2'd2, 1'b0, 0);
        transact(10'h013, 1'b0, 32'd0, 2'd0, 1'b1, 0);
        transact(10'h013, 1'b0, 32'd0, 2'd0, 1'b0, 0);
        transact(10'h010, 1'b0, 32'd0, 2'd1, 1'b1, 0);
        transact(10'h011, 1'b1, 32'h00000055, 2'd0, 1'b0, 0);
        transact(10'h010, 1'b0, 32'd0, 2'd2, 1'b0, 0);

        // Misaligned and reserved
        transact(10'h012, 1'b1, 32'hFFFFFFFF, 2'd2, 1'b0, 0);
        transact(10'h010, 1'b0, 32'd0, 2'd2, 1'b0, 0);
        transact(10'h011, 1'b0, 32'd0, 2'd1, 1'b0, 0);
        transact(10'h000, 1'b0, 32'd0, 2'd3, 1'b0, 0);
        transact(10'h3FC, 1'b1, 32'hA5A5C3C3, 2'd2, 1'b0, 0);
        transact(10'h3FE, 1'b0, 32'd0, 2'd1, 1'b1, 0);

        // Back-pressure
        transact(10'h010, 1'b0, 32'd0, 2'd2, 1'b0, 5);

        // Reset during WAIT (d=0,1) and during ACCESS (d=2): store must not land
        for (int d = 0; d < 3; d++) begin
            accept_req(10'h020, 1'b1, 32'h12345678, 2'd2, 1'b0, ok);
            repeat (d) @(posedge clk);
            #1;
            reset = 1'b1;
            @(posedge clk);
            #1;
            check("midreset_valid", 32'(rsp_valid), 32'd0);
            check("midreset_ready", 32'(req_ready), 32'd0);
            reset = 1'b0;
            #1;
            check("postreset_valid", 32'(rsp_valid), 32'd0);
            check("postreset_ready", 32'(req_ready), 32'd1);
            transact(10'h020, 1'b0, 32'd0, 2'd2, 1'b0, 0);
        end

        // Random traffic over the initialised region
        for (int n = 0; n < 300; n++) begin
            transact(ADDR_W'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), $urandom,
                     2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
